// File: rtl/button_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | button_debounce: two-flop pin synchroniser with debounce FSM that emits   |
// | press/release/long-press pulses, a stable level and a press counter.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module button_debounce #(
  parameter logic [31:0] DEBOUNCE_LIMIT   = 32'd1000000,
  parameter logic [31:0] LONG_PRESS_LIMIT = 32'd50000000,
  parameter logic        ACTIVE_LOW       = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic [7:0] press_count
);

  localparam logic [31:0] c_deb_last  = DEBOUNCE_LIMIT - 32'd1;
  localparam logic [31:0] c_hold_last = LONG_PRESS_LIMIT - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_PRESSED     = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [31:0] r_deb_cnt;
  logic [31:0] r_hold_cnt;
  logic        r_long_fired;
  logic        w_act;

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign w_act = r_sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Sync flops park at the idle pin level so leaving reset never looks like a press.
      r_sync1          <= ACTIVE_LOW;
      r_sync2          <= ACTIVE_LOW;
      r_state          <= S_IDLE;
      r_deb_cnt        <= 32'd0;
      r_hold_cnt       <= 32'd0;
      r_long_fired     <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      press_count      <= 8'd0;
    end else begin
      r_sync1          <= btn_in;
      r_sync2          <= r_sync1;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_act) begin
            r_state   <= S_DEB_PRESS;
            r_deb_cnt <= 32'd0;
          end
        end

        S_DEB_PRESS: begin
          if (!w_act) begin
            r_state <= S_IDLE;
          end else if (r_deb_cnt == c_deb_last) begin
            r_state      <= S_PRESSED;
            btn_level    <= 1'b1;
            press_pulse  <= 1'b1;
            press_count  <= press_count + 8'd1;
            r_hold_cnt   <= 32'd0;
            r_long_fired <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 32'd1;
          end
        end

        S_PRESSED: begin
          if (!w_act) begin
            r_state   <= S_DEB_RELEASE;
            r_deb_cnt <= 32'd0;
          end else if ((r_hold_cnt == c_hold_last) && !r_long_fired) begin
            long_press_pulse <= 1'b1;
            r_long_fired     <= 1'b1;
          end else if (!r_long_fired) begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
          end
        end

        S_DEB_RELEASE: begin
          // A bounce back to pressed resumes the hold timing where it stopped.
          if (w_act) begin
            r_state <= S_PRESSED;
          end else if (r_deb_cnt == c_deb_last) begin
            r_state       <= S_IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + 32'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
